// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//   REG_ADDR_W / NUM_REGS : register-file geometry
//   X0_ADDR               : hard-wired zero register
//   FIFO entry layout     : {rd[REG_ADDR_W-1:0], data[WIDTH-1:0]}, rd in the MSBs
package wb_port_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t X0_ADDR = '0;

    // Width of one buffered MDU result for a given data width.
    function automatic int entry_width(input int data_w);
        return REG_ADDR_W + data_w;
    endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Small FIFO holding MDU results waiting for a free register-file write slot.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   push, push_entry : enqueue one entry (caller guarantees !full)
//   pop           : dequeue the head (caller guarantees !empty)
//   head_entry    : current head, valid while !empty
//   full, empty   : occupancy flags from the registered count
//   count         : number of stored entries, 0..DEPTH
module wb_result_fifo #(
    parameter int ENTRY_W = 37,
    parameter int DEPTH   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [ENTRY_W-1:0]         push_entry,
    input  logic                       pop,
    output logic [ENTRY_W-1:0]         head_entry,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_q;

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_entry = mem[rd_ptr];
    assign count      = count_q;
    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the in-order pipeline
// writeback (absolute priority, never stalled here) and the MDU, whose
// results are buffered until a free slot appears. Keeps a per-register
// pending scoreboard and asks the hazard unit for a bubble when MDU results
// are starved.
// Ports:
//   clk, rst_n                   : clock, asynchronous active-low reset
//   pipe_wb_valid/rd/data        : WB-stage regWrite, destination and mux output
//   mdu_issue_valid/rd           : MDU op issued this cycle and its destination
//   mdu_res_valid/rd/data, mdu_res_ready : MDU result handshake
//   rf_we, rf_waddr, rf_wdata    : register-file write port
//   pending                      : bit i set = MDU write to xi outstanding
//   stall_req                    : registered bubble request for the WB stage
//   proto_err                    : sticky protocol-violation flag
//
// Handshake: an MDU result transfers in any cycle where mdu_res_valid and
// mdu_res_ready are both high at the rising edge. ready depends only on the
// registered FIFO count (never on valid or on a same-cycle pop); the MDU
// must hold valid/rd/data stable until the transfer completes.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pipe_wb_valid,
    input  logic [REG_ADDR_W-1:0] pipe_wb_rd,
    input  logic [WIDTH-1:0]      pipe_wb_data,
    input  logic                  mdu_issue_valid,
    input  logic [REG_ADDR_W-1:0] mdu_issue_rd,
    input  logic                  mdu_res_valid,
    input  logic [REG_ADDR_W-1:0] mdu_res_rd,
    input  logic [WIDTH-1:0]      mdu_res_data,
    output logic                  mdu_res_ready,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [WIDTH-1:0]      rf_wdata,
    output logic [NUM_REGS-1:0]   pending,
    output logic                  stall_req,
    output logic                  proto_err
);

    localparam int ENTRY_W  = entry_width(WIDTH);
    localparam int CNT_W    = $clog2(DEPTH) + 1;
    localparam int STARVE_W = 4;
    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic                  pipe_win;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [ENTRY_W-1:0]    head_entry;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [WIDTH-1:0]      head_data;
    logic                  res_accept;

    logic [NUM_REGS-1:0]   pending_q, pending_nxt, set_mask, clr_mask;
    logic [STARVE_W-1:0]   starve_q, starve_nxt;
    logic                  stall_q, stall_nxt;
    logic                  proto_q, proto_nxt;

    assign pipe_win  = pipe_wb_valid && (pipe_wb_rd != X0_ADDR);
    assign head_rd   = head_entry[ENTRY_W-1 -: REG_ADDR_W];
    assign head_data = head_entry[WIDTH-1:0];

    // The FIFO gets the port only when the pipe does not want it.
    assign fifo_pop = rst_n && !pipe_win && !fifo_empty;

    assign mdu_res_ready = rst_n && (fifo_count < CNT_W'(DEPTH));
    assign res_accept    = mdu_res_valid && mdu_res_ready;
    // x0 results complete the handshake but are dropped here.
    assign fifo_push     = res_accept && (mdu_res_rd != X0_ADDR) && !fifo_full;

    wb_result_fifo #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fifo_push),
        .push_entry ({mdu_res_rd, mdu_res_data}),
        .pop        (fifo_pop),
        .head_entry (head_entry),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // Write port: zero-latency mux, forced idle during reset.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (rst_n) begin
            if (pipe_win) begin
                rf_we    = 1'b1;
                rf_waddr = pipe_wb_rd;
                rf_wdata = pipe_wb_data;
            end else if (!fifo_empty) begin
                rf_we    = 1'b1;
                rf_waddr = head_rd;
                rf_wdata = head_data;
            end
        end
    end

    // Scoreboard: set on issue, clear on FIFO retirement; set wins.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (mdu_issue_valid && (mdu_issue_rd != X0_ADDR)) begin
            set_mask[mdu_issue_rd] = 1'b1;
        end
        if (fifo_pop) begin
            clr_mask[head_rd] = 1'b1;
        end
        pending_nxt    = (pending_q & ~clr_mask) | set_mask;
        pending_nxt[0] = 1'b0;
    end

    // Starvation: count blocked cycles; stall_req rises on the edge where
    // the count reaches the limit and drops on the edge of the next pop.
    always_comb begin
        starve_nxt = starve_q;
        if (fifo_pop || fifo_empty) begin
            starve_nxt = '0;
        end else if (pipe_win && (starve_q < LIMIT)) begin
            starve_nxt = starve_q + STARVE_W'(1);
        end

        stall_nxt = stall_q;
        if (fifo_pop) begin
            stall_nxt = 1'b0;
        end else if (starve_nxt == LIMIT) begin
            stall_nxt = 1'b1;
        end
    end

    always_comb begin
        proto_nxt = proto_q;
        if (pipe_win && pending_q[pipe_wb_rd]) begin
            proto_nxt = 1'b1;
        end
        if (mdu_issue_valid && (mdu_issue_rd != X0_ADDR) && pending_q[mdu_issue_rd]) begin
            proto_nxt = 1'b1;
        end
        if (res_accept && (mdu_res_rd != X0_ADDR) && !pending_q[mdu_res_rd]) begin
            proto_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            starve_q  <= '0;
            stall_q   <= 1'b0;
            proto_q   <= 1'b0;
        end else begin
            pending_q <= pending_nxt;
            starve_q  <= starve_nxt;
            stall_q   <= stall_nxt;
            proto_q   <= proto_nxt;
        end
    end

    assign pending   = pending_q;
    assign stall_req = stall_q;
    assign proto_err = proto_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pipe_wb_valid = 1'b0;
    logic [4:0]       pipe_wb_rd = '0;
    logic [WIDTH-1:0] pipe_wb_data = '0;
    logic             mdu_issue_valid = 1'b0;
    logic [4:0]       mdu_issue_rd = '0;
    logic             mdu_res_valid = 1'b0;
    logic [4:0]       mdu_res_rd = '0;
    logic [WIDTH-1:0] mdu_res_data = '0;
    logic             mdu_res_ready;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [WIDTH-1:0] rf_wdata;
    logic [31:0]      pending;
    logic             stall_req;
    logic             proto_err;

    int tests_run = 0;
    int tests_failed = 0;

    wb_port_arbiter #(
        .WIDTH        (WIDTH),
        .DEPTH        (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pipe_wb_valid   (pipe_wb_valid),
        .pipe_wb_rd      (pipe_wb_rd),
        .pipe_wb_data    (pipe_wb_data),
        .mdu_issue_valid (mdu_issue_valid),
        .mdu_issue_rd    (mdu_issue_rd),
        .mdu_res_valid   (mdu_res_valid),
        .mdu_res_rd      (mdu_res_rd),
        .mdu_res_data    (mdu_res_data),
        .mdu_res_ready   (mdu_res_ready),
        .rf_we           (rf_we),
        .rf_waddr        (rf_waddr),
        .rf_wdata        (rf_wdata),
        .pending         (pending),
        .stall_req       (stall_req),
        .proto_err       (proto_err)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Checking
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drivers: inputs change just after the falling edge, checks run 1ns later.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic pipe(input logic v, input logic [4:0] rd, input logic [WIDTH-1:0] d);
        pipe_wb_valid = v;
        pipe_wb_rd    = rd;
        pipe_wb_data  = d;
    endtask

    task automatic issue(input logic v, input logic [4:0] rd);
        mdu_issue_valid = v;
        mdu_issue_rd    = rd;
    endtask

    task automatic result(input logic v, input logic [4:0] rd, input logic [WIDTH-1:0] d);
        mdu_res_valid = v;
        mdu_res_rd    = rd;
        mdu_res_data  = d;
    endtask

    task automatic check_port(input string tag, input logic we, input logic [4:0] a, input logic [WIDTH-1:0] d);
        check({tag, "_we"}, 64'(rf_we), 64'(we));
        check({tag, "_waddr"}, 64'(rf_waddr), 64'(a));
        check({tag, "_wdata"}, 64'(rf_wdata), 64'(d));
    endtask

    initial begin
        // Reset state, with the pipe trying to write
        pipe(1'b1, 5'd3, 32'h5555);
        step();
        settle();
        check_port("rst", 1'b0, 5'd0, 32'h0);
        check("rst_ready", 64'(mdu_res_ready), 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_stall", 64'(stall_req), 64'd0);
        check("rst_proto", 64'(proto_err), 64'd0);
        pipe(1'b0, 5'd0, 32'h0);
        rst_n = 1'b1;
        settle();
        check("rel_ready", 64'(mdu_res_ready), 64'd1);

        // MDU only
        step();
        issue(1'b1, 5'd5);
        step();
        issue(1'b0, 5'd0);
        result(1'b1, 5'd5, 32'h1234);
        settle();
        check("mdu_pend_set", 64'(pending), 64'h20);
        check("mdu_ready", 64'(mdu_res_ready), 64'd1);
        check("mdu_idle_we", 64'(rf_we), 64'd0);
        step();
        result(1'b0, 5'd0, 32'h0);
        settle();
        check_port("mdu_wr", 1'b1, 5'd5, 32'h1234);
        check("mdu_pend_hold", 64'(pending), 64'h20);
        step();
        settle();
        check("mdu_done_we", 64'(rf_we), 64'd0);
        check("mdu_pend_clr", 64'(pending), 64'h0);
        check("mdu_proto", 64'(proto_err), 64'd0);

        // Conflict: pipe and MDU in the same cycle
        issue(1'b1, 5'd7);
        step();
        issue(1'b0, 5'd0);
        pipe(1'b1, 5'd3, 32'hAAAA);
        result(1'b1, 5'd7, 32'hBBBB);
        settle();
        check_port("cf_pipe", 1'b1, 5'd3, 32'hAAAA);
        check("cf_ready", 64'(mdu_res_ready), 64'd1);
        step();
        pipe(1'b0, 5'd0, 32'h0);
        result(1'b0, 5'd0, 32'h0);
        settle();
        check_port("cf_mdu", 1'b1, 5'd7, 32'hBBBB);
        step();
        settle();
        check("cf_empty_we", 64'(rf_we), 64'd0);
        check("cf_pend", 64'(pending), 64'h0);
        check("cf_proto", 64'(proto_err), 64'd0);

        // Backpressure with the pipe writing every cycle
        for (int i = 10; i <= 12; i++) begin
            issue(1'b1, 5'(i));
            step();
        end
        issue(1'b0, 5'd0);
        settle();
        check("bp_pend", 64'(pending), 64'h1C00);
        pipe(1'b1, 5'd1, 32'h0101);
        result(1'b1, 5'd10, 32'h10A);
        settle();
        check("bp_ready_a", 64'(mdu_res_ready), 64'd1);
        step();
        result(1'b1, 5'd11, 32'h10B);
        settle();
        check("bp_ready_b", 64'(mdu_res_ready), 64'd1);
        check_port("bp_pipe_b", 1'b1, 5'd1, 32'h0101);
        step();
        result(1'b1, 5'd12, 32'h10C);
        settle();
        check("bp_ready_c", 64'(mdu_res_ready), 64'd0);
        step();
        pipe(1'b0, 5'd0, 32'h0);
        settle();
        check("bp_ready_pop", 64'(mdu_res_ready), 64'd0);
        check_port("bp_pop10", 1'b1, 5'd10, 32'h10A);
        step();
        settle();
        check("bp_ready_e", 64'(mdu_res_ready), 64'd1);
        check_port("bp_pop11", 1'b1, 5'd11, 32'h10B);
        step();
        result(1'b0, 5'd0, 32'h0);
        settle();
        check_port("bp_pop12", 1'b1, 5'd12, 32'h10C);
        step();
        settle();
        check("bp_end_we", 64'(rf_we), 64'd0);
        check("bp_end_pend", 64'(pending), 64'h0);
        check("bp_stall", 64'(stall_req), 64'd0);

        // Starvation
        issue(1'b1, 5'd20);
        step();
        issue(1'b0, 5'd0);
        result(1'b1, 5'd20, 32'h2020);
        step();
        result(1'b0, 5'd0, 32'h0);
        pipe(1'b1, 5'd2, 32'h0202);
        for (int c = 1; c <= 4; c++) begin
            settle();
            check($sformatf("sv_stall_c%0d", c), 64'(stall_req), 64'd0);
            step();
        end
        settle();
        check("sv_stall_c5", 64'(stall_req), 64'd1);
        step();
        settle();
        check("sv_stall_c6", 64'(stall_req), 64'd1);
        check_port("sv_pipe_wins", 1'b1, 5'd2, 32'h0202);
        step();
        pipe(1'b0, 5'd0, 32'h0);
        settle();
        check("sv_stall_pop", 64'(stall_req), 64'd1);
        check_port("sv_pop", 1'b1, 5'd20, 32'h2020);
        step();
        settle();
        check("sv_stall_clr", 64'(stall_req), 64'd0);
        check("sv_pend", 64'(pending), 64'h0);

        // x0 result is accepted and dropped
        result(1'b1, 5'd0, 32'hDEAD);
        settle();
        check("x0_ready", 64'(mdu_res_ready), 64'd1);
        check("x0_we", 64'(rf_we), 64'd0);
        step();
        result(1'b0, 5'd0, 32'h0);
        settle();
        check("x0_no_wr", 64'(rf_we), 64'd0);
        check("x0_proto", 64'(proto_err), 64'd0);

        // Pipe write to a pending register
        issue(1'b1, 5'd9);
        step();
        issue(1'b0, 5'd0);
        pipe(1'b1, 5'd9, 32'h99);
        settle();
        check_port("waw_pipe", 1'b1, 5'd9, 32'h99);
        check("waw_proto_pre", 64'(proto_err), 64'd0);
        step();
        pipe(1'b0, 5'd0, 32'h0);
        settle();
        check("waw_proto", 64'(proto_err), 64'd1);
        step();
        step();
        settle();
        check("waw_sticky", 64'(proto_err), 64'd1);
        check("waw_pend", 64'(pending), 64'h200);
        rst_n = 1'b0;
        settle();
        check("waw_rst_proto", 64'(proto_err), 64'd0);
        check("waw_rst_pend", 64'(pending), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Async reset with the FIFO full
        issue(1'b1, 5'd5);
        step();
        issue(1'b1, 5'd7);
        step();
        issue(1'b0, 5'd0);
        pipe(1'b1, 5'd1, 32'h0111);
        result(1'b1, 5'd5, 32'h5);
        step();
        result(1'b1, 5'd7, 32'h7);
        step();
        result(1'b0, 5'd0, 32'h0);
        settle();
        check("ar_full_ready", 64'(mdu_res_ready), 64'd0);
        check("ar_pend", 64'(pending), 64'hA0);
        rst_n = 1'b0;
        settle();
        check("ar_we", 64'(rf_we), 64'd0);
        check("ar_pend_clr", 64'(pending), 64'h0);
        check("ar_ready", 64'(mdu_res_ready), 64'd0);
        check("ar_stall", 64'(stall_req), 64'd0);
        @(negedge clk);
        pipe(1'b0, 5'd0, 32'h0);
        rst_n = 1'b1;
        settle();
        check("ar_rel_ready", 64'(mdu_res_ready), 64'd1);
        check("ar_rel_we", 64'(rf_we), 64'd0);
        step();
        settle();
        check("ar_lost_we", 64'(rf_we), 64'd0);

        // Final report
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two sources.
- Source 1: the in-order pipeline writeback result, i.e. the WriteBack mux output plus regWrite. It has absolute priority and is never stalled by this block.
- Source 2: a multi-cycle unit (MDU: mul/div) that returns results asynchronously to the pipeline through a valid/ready handshake.
- Buffers MDU results in a small FIFO, keeps a per-register pending scoreboard for the hazard unit, and requests a pipeline stall when MDU results starve.

Parameters:
- WIDTH, 32, data width of the register file.
- DEPTH, 2, MDU result FIFO entries; power of 2, ≥2.
- STARVE_LIMIT, 4, consecutive blocked cycles before stall_req is raised; range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- pipe_wb_valid  in  1  WB-stage regWrite.
- pipe_wb_rd  in  5  WB-stage destination register.
- pipe_wb_data  in  WIDTH  WB mux output.
- mdu_issue_valid  in  1  MDU op issued this cycle.
- mdu_issue_rd  in  5  destination of issued MDU op.
- mdu_res_valid  in  1  MDU result available.
- mdu_res_rd  in  5  MDU result destination.
- mdu_res_data  in  WIDTH  MDU result value.
- mdu_res_ready  out  1  block accepts MDU result this cycle.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  WIDTH  register-file write data.
- pending  out  32  bit i set means an MDU write to xi is outstanding.
- stall_req  out  1  request to the hazard unit to bubble the WB stage.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (async, while rst_n=0):
  - FIFO empty, pending=0, starve_cnt=0, stall_req=0, proto_err=0.
  - rf_we is forced 0 regardless of inputs.
  - mdu_res_ready=0 while in reset.
- pipe_win = pipe_wb_valid && pipe_wb_rd!=0.
- RF port (combinational, zero latency):
  - If pipe_win: rf_we=1, address/data taken from the pipe.
  - Else if FIFO non-empty: rf_we=1, address/data taken from the FIFO head, and the head is popped at the clock edge.
  - Else rf_we=0, with rf_waddr=0 and rf_wdata=0.
- A pipe write to x0 never asserts rf_we and does not block the FIFO.
- mdu_res_ready = (count < DEPTH).
  - Derived from registered count only; there is no combinational path from pop to ready.
  - Full plus simultaneous pop still gives ready=0 that cycle.
- Push on mdu_res_valid && mdu_res_ready && mdu_res_rd!=0.
  - An x0 result is accepted (handshake completes) and discarded without enqueue.
- Push and pop in the same cycle: both take effect; count is unchanged.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Scoreboard:
  - pending[mdu_issue_rd] is set on mdu_issue_valid && mdu_issue_rd!=0.
  - pending[rf_waddr] is cleared when a FIFO pop writes the RF.
  - Set and clear of the same bit in the same cycle: set wins.
  - pending[0] is always 0.
- Starvation counter:
  - starve_cnt increments, saturating at STARVE_LIMIT, in each cycle the FIFO is non-empty and pipe_win=1.
  - starve_cnt clears on any pop, or when the FIFO is empty.
  - stall_req is registered. It is set the cycle after starve_cnt reaches STARVE_LIMIT and held until the cycle after the next pop.
  - The pipe still wins if it presents a write while stall_req=1; correctness does not depend on the hazard unit honouring the request.
- proto_err is set (sticky until reset) on any of:
  - pipe_win with pending[pipe_wb_rd]=1 (WAW hazard escaped the hazard unit);
  - mdu_issue_valid to an already-pending nonzero rd;
  - an accepted MDU result with nonzero rd whose pending bit is 0.
- Reset mid-operation: buffered results are lost. pending clears and all outputs return to their reset values asynchronously.

Decomposition:
- Shared package/include holds:
  - REG_ADDR_W=5, NUM_REGS=32, the x0 address constant;
  - the FIFO entry layout {rd[4:0], data[WIDTH-1:0]}.
- One natural sub-module: wb_result_fifo (DEPTH x (5+WIDTH)).
  - Synchronous push/pop, async active-low reset, with full, empty and count outputs.
- Scoreboard, arbitration and starvation logic stay in the top level.

Test Plan:
- MDU only: issue x5, then return result x5=0x1234 with the pipe idle → handshake completes; next cycle rf_we=1, waddr=5, wdata=0x1234 (combinational from the FIFO head); pending[5] 1→0 after pop; proto_err=0.
- Conflict: pipe x3=0xAAAA and MDU result x7=0xBBBB in the same cycle → cycle N writes x3; cycle N+1 writes x7=0xBBBB; no data lost.
- Backpressure: DEPTH=2, pipe writes every cycle, MDU offers 3 results → first two accepted, mdu_res_ready=0 on the third until the first pop.
- Starvation: FIFO holds 1 entry, pipe writes nonzero rd for 4 consecutive cycles → stall_req=1 from cycle 5. Pipe idles → pop occurs, then stall_req=0 the following cycle.
- x0 and protocol checks:
  - MDU result to x0 → accepted, no rf_we.
  - Pipe write to x9 while pending[9]=1 → proto_err=1, held until rst_n low.
- Async reset mid-operation: rst_n low with FIFO full and pending=0x0000_00A0 → immediately rf_we=0, pending=0, mdu_res_ready=0, stall_req=0; after release, mdu_res_ready=1.
